// File: rtl/conv_acc_quant.sv
// conv_acc_quant: accumulates per-column MAC partial sums over a group of beats,
// then adds bias, rounds, shifts, optionally applies ReLU and saturates each lane.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : partial-sum beat handshake
//   in_first/in_last    : group delimiters for the accumulation
//   in_data             : COLUMN signed lanes of OW bits
//   bias/shift/relu_en  : quantisation controls, sampled on the last beat
//   out_valid/out_ready : quantised result handshake
//   out_data            : COLUMN signed lanes of QW bits
module conv_acc_quant #(
    parameter int COLUMN = 7,
    parameter int OW     = 26,
    parameter int AW     = 32,
    parameter int BW     = 16,
    parameter int QW     = 8,
    parameter int SHW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [COLUMN*OW-1:0] in_data,
    input  logic [COLUMN*BW-1:0] bias,
    input  logic [SHW-1:0]       shift,
    input  logic                 relu_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COLUMN*QW-1:0] out_data
);
    // Two guard bits keep sum + bias + rounding free of overflow.
    localparam int TW = AW + 2;
    localparam logic signed [AW-1:0] ACC_ZERO = '0;
    localparam logic signed [TW-1:0] QMAX = TW'(2 ** (QW - 1) - 1);
    localparam logic signed [TW-1:0] QMIN = ~QMAX;

    logic signed [AW-1:0] acc_q [COLUMN];
    logic signed [AW-1:0] q_sum_q [COLUMN];
    logic signed [AW-1:0] sum [COLUMN];
    logic [COLUMN*BW-1:0] q_bias_q;
    logic [SHW-1:0]       q_shift_q;
    logic                 q_relu_q;
    logic                 q_valid_q, q_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [COLUMN*QW-1:0] out_data_q, res;
    logic                 accept, capture, q_adv;

    assign q_adv     = q_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !q_valid_q || q_adv;
    assign accept    = in_valid && in_ready;
    assign capture   = accept && in_last;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        q_valid_d   = capture ? 1'b1 : (q_adv ? 1'b0 : q_valid_q);
        out_valid_d = q_adv ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    for (genvar i = 0; i < COLUMN; i++) begin : g_lane
        logic signed [OW-1:0] lane;
        logic signed [BW-1:0] b;
        logic signed [TW-1:0] rnd, t0, t1, t2;
        assign lane   = in_data[i*OW +: OW];
        assign b      = q_bias_q[i*BW +: BW];
        assign sum[i] = (in_first ? ACC_ZERO : acc_q[i]) + AW'(lane);
        always_comb begin
            // Adding half an LSB before the arithmetic shift rounds half-up.
            rnd = (q_shift_q != '0) ? (TW'(1) <<< (q_shift_q - SHW'(1))) : TW'(0);
            t0  = TW'(q_sum_q[i]) + TW'(b) + rnd;
            t1  = t0 >>> q_shift_q;
            t2  = (q_relu_q && t1 < 0) ? TW'(0) : t1;
        end
        assign res[i*QW +: QW] = (t2 > QMAX) ? QMAX[QW-1:0] :
                                 (t2 < QMIN) ? QMIN[QW-1:0] : t2[QW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < COLUMN; k++) begin
                acc_q[k]   <= '0;
                q_sum_q[k] <= '0;
            end
            q_bias_q    <= '0;
            q_shift_q   <= '0;
            q_relu_q    <= 1'b0;
            q_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // The accumulator keeps the group sum after a last beat.
            if (accept) begin
                for (int k = 0; k < COLUMN; k++) acc_q[k] <= sum[k];
            end
            if (capture) begin
                for (int k = 0; k < COLUMN; k++) q_sum_q[k] <= sum[k];
                q_bias_q  <= bias;
                q_shift_q <= shift;
                q_relu_q  <= relu_en;
            end
            if (q_adv) out_data_q <= res;
            q_valid_q   <= q_valid_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_conv_acc_quant.sv
// tb_conv_acc_quant: directed and randomized checks of conv_acc_quant against an arithmetic model.
module tb_conv_acc_quant;
    localparam int COLUMN = 7;
    localparam int OW     = 26;
    localparam int AW     = 32;
    localparam int BW     = 16;
    localparam int QW     = 8;
    localparam int SHW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_first = 1'b0;
    logic                 in_last = 1'b0;
    logic [COLUMN*OW-1:0] in_data = '0;
    logic [COLUMN*BW-1:0] bias = '0;
    logic [SHW-1:0]       shift = '0;
    logic                 relu_en = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [COLUMN*QW-1:0] out_data;

    conv_acc_quant #(.COLUMN(COLUMN), .OW(OW), .AW(AW), .BW(BW), .QW(QW), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .in_data(in_data), .bias(bias),
        .shift(shift), .relu_en(relu_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    longint acc_m [COLUMN];
    int lv [COLUMN];
    int bv [COLUMN];
    int ev [COLUMN];
    logic [COLUMN*QW-1:0] expq [$];
    bit auto_exp = 1'b0;
    bit hold_v = 1'b0;
    logic [COLUMN*QW-1:0] hold_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic longint wrap(input longint x);
        return longint'(int'(x));
    endfunction

    function automatic logic [QW-1:0] quant(input longint s, input longint b, input int sh, input bit relu);
        longint t, hi, lo;
        hi = (longint'(1) <<< (QW - 1)) - 1;
        lo = -hi - 1;
        t = s + b;
        if (sh > 0) t = t + (longint'(1) <<< (sh - 1));
        t = t >>> sh;
        if (relu && t < 0) t = 0;
        if (t > hi) t = hi;
        if (t < lo) t = lo;
        return t[QW-1:0];
    endfunction

    task automatic push_ev();
        logic [COLUMN*QW-1:0] v;
        for (int k = 0; k < COLUMN; k++) v[k*QW +: QW] = QW'(ev[k]);
        expq.push_back(v);
    endtask

    task automatic push_all(input int x);
        for (int k = 0; k < COLUMN; k++) ev[k] = x;
        push_ev();
    endtask

    task automatic set_all(input int x, input int b);
        for (int k = 0; k < COLUMN; k++) begin
            lv[k] = x;
            bv[k] = b;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, then update the model.
    task automatic beat(input bit first, input bit last, input int sh, input bit relu);
        int n;
        logic [COLUMN*QW-1:0] v;
        for (int k = 0; k < COLUMN; k++) begin
            in_data[k*OW +: OW] = OW'(lv[k]);
            bias[k*BW +: BW]    = BW'(bv[k]);
        end
        in_first = first;
        in_last  = last;
        shift    = SHW'(sh);
        relu_en  = relu;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (n >= 2) out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 200), 64'd1);
        for (int k = 0; k < COLUMN; k++)
            acc_m[k] = first ? longint'(lv[k]) : wrap(acc_m[k] + longint'(lv[k]));
        if (last && auto_exp) begin
            for (int k = 0; k < COLUMN; k++) v[k*QW +: QW] = quant(acc_m[k], longint'(bv[k]), sh, relu);
            expq.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Output monitor: checks every transfer against the expected queue and
    // that a stalled result stays put.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {out_valid, out_data}, {1'b1, hold_d});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
                else chk("out_data", out_data, expq.pop_front());
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    initial begin
        logic signed [OW-1:0] r;
        logic signed [BW-1:0] rb;
        int len, sh;
        bit relu;
        for (int k = 0; k < COLUMN; k++) acc_m[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Three-beat group saturating high, plus latency.
        set_all(100, 0);
        beat(1, 0, 0, 0);
        set_all(200, 0);
        beat(0, 0, 0, 0);
        set_all(-50, 0);
        push_all(127);
        beat(0, 1, 0, 0);
        @(negedge clk);
        chk("latency_q", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_out", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Rounding with shift 1.
        lv = '{5, 6, -5, -6, 7, 0, 1};
        bv = '{0, 0, 0, 0, 0, 0, 0};
        ev = '{3, 3, -2, -3, 4, 0, 1};
        push_ev();
        beat(1, 1, 1, 0);

        // Bias with and without ReLU.
        lv = '{-10, 10, 0, 0, 0, 0, 0};
        bv = '{4, -20, 0, 0, 0, 0, 0};
        push_all(0);
        beat(1, 1, 0, 1);
        ev = '{-6, -10, 0, 0, 0, 0, 0};
        push_ev();
        beat(1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two groups fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        set_all(1, 0);
        push_all(1);
        beat(1, 1, 0, 0);
        set_all(2, 0);
        push_all(2);
        beat(1, 1, 0, 0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready_valid", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_all(3, 0);
        push_all(3);
        beat(1, 1, 0, 0);
        set_all(4, 0);
        push_all(4);
        beat(1, 1, 0, 0);
        repeat (4) @(negedge clk);
        chk("bp_drained", 64'(expq.size()), 64'd0);
        @(posedge clk);
        #1;

        // Negative saturation, then accumulator wrap past 2^31.
        set_all(-(1 << 25), 0);
        push_all(-128);
        beat(1, 0, 0, 0);
        beat(0, 1, 0, 0);
        set_all((1 << 25) - 1, 0);
        push_all(-1);
        beat(1, 0, 0, 0);
        repeat (63) beat(0, 0, 0, 0);
        beat(0, 1, 31, 0);
        repeat (3) @(posedge clk);
        #1;

        // Reset with a partial group and a held output.
        out_ready = 1'b0;
        set_all(3, 0);
        push_all(3);
        beat(1, 1, 0, 0);
        set_all(5, 0);
        beat(1, 0, 0, 0);
        beat(0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        expq.delete();
        for (int k = 0; k < COLUMN; k++) acc_m[k] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        set_all(9, 0);
        push_all(9);
        beat(0, 1, 0, 0);
        repeat (4) @(negedge clk);
        chk("post_rst_drained", 64'(expq.size()), 64'd0);
        @(posedge clk);
        #1;

        // Randomized groups checked against the arithmetic model.
        auto_exp = 1'b1;
        for (int g = 0; g < 40; g++) begin
            len  = $urandom_range(1, 4);
            sh   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(18, 27);
            relu = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                for (int k = 0; k < COLUMN; k++) begin
                    r = OW'($urandom);
                    lv[k] = int'(r);
                    rb = BW'($urandom);
                    bv[k] = int'(rb);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                beat(b == 0, b == len - 1, sh, relu);
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("final_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
